// File: rtl/rtc_timekeeper_pkg.sv
// Shared types and range limits for the real-time-clock timekeeper.
package rtc_pkg;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  // Time of day in 24-hour binary form; bit layout matches the set_time port.
  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
  } rtc_time_t;

  // True when every field of t is a legal time-of-day value.
  function automatic logic rtc_valid(rtc_time_t t);
    return (int'(t.hours) <= HOUR_MAX) &&
           (int'(t.minutes) <= MIN_MAX) &&
           (int'(t.seconds) <= SEC_MAX);
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides the system clock down to a one-second tick. The tick output is a
// combinational "this cycle ends a second" condition; the parent registers it.
module rtc_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_cnt;

  assign tick = run && (r_cnt == LAST);

  // Count 0..TICK_DIV-1 while running; a clear (valid load) restarts the second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run) begin
      if (r_cnt == LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rtc_timekeeper.sv
// Time-of-day counter (hh:mm:ss, 24-hour) with prescaler, validated load,
// one-shot sticky alarm and a combinational 12-hour display view.
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter bit ALARM_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        set_en,
  input  logic [16:0] set_time,
  input  logic [10:0] alarm_time,
  input  logic        alarm_arm,
  input  logic        alarm_ack,
  output logic [5:0]  seconds,
  output logic [5:0]  minutes,
  output logic [4:0]  hours,
  output logic [3:0]  hours12,
  output logic        pm,
  output logic        sec_tick,
  output logic        set_err,
  output logic        alarm_flag
);

  rtc_time_t r_time;
  rtc_time_t w_set;
  rtc_time_t w_inc;
  logic      r_sec_tick;
  logic      r_set_err;
  logic      w_tick;
  logic      w_load_ok;
  logic      w_load_bad;
  logic      w_adv;
  logic [3:0] w_hours12;

  assign w_set      = set_time;
  assign w_load_ok  = set_en && rtc_valid(w_set);
  assign w_load_bad = set_en && !rtc_valid(w_set);
  // A valid load swallows a coincident tick.
  assign w_adv      = w_tick && !w_load_ok;

  rtc_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .run (run),
    .clr (w_load_ok),
    .tick(w_tick)
  );

  // Time one second after the current one, with minute/hour/day carries.
  always_comb begin
    w_inc = r_time;
    if (r_time.seconds == 6'(SEC_MAX)) begin
      w_inc.seconds = '0;
      if (r_time.minutes == 6'(MIN_MAX)) begin
        w_inc.minutes = '0;
        if (r_time.hours == 5'(HOUR_MAX)) begin
          w_inc.hours = '0;
        end else begin
          w_inc.hours = r_time.hours + 1'b1;
        end
      end else begin
        w_inc.minutes = r_time.minutes + 1'b1;
      end
    end else begin
      w_inc.seconds = r_time.seconds + 1'b1;
    end
  end

  // Time register plus the one-cycle tick and load-error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_time     <= '0;
      r_sec_tick <= 1'b0;
      r_set_err  <= 1'b0;
    end else begin
      r_sec_tick <= w_adv;
      r_set_err  <= w_load_bad;
      if (w_load_ok) begin
        r_time <= w_set;
      end else if (w_adv) begin
        r_time <= w_inc;
      end
    end
  end

  generate
    if (ALARM_EN) begin : g_alarm
      logic r_alarm_flag;
      logic w_hit;

      // Only a tick landing on hh:mm:00 fires; out-of-range alarm values never match.
      assign w_hit = alarm_arm && w_adv &&
                     (w_inc.hours == alarm_time[10:6]) &&
                     (w_inc.minutes == alarm_time[5:0]) &&
                     (w_inc.seconds == 6'd0);

      // Sticky flag: a new hit beats a coincident acknowledge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_alarm_flag <= 1'b0;
        end else if (w_hit) begin
          r_alarm_flag <= 1'b1;
        end else if (alarm_ack) begin
          r_alarm_flag <= 1'b0;
        end
      end

      assign alarm_flag = r_alarm_flag;
    end else begin : g_no_alarm
      logic w_unused_alarm;
      assign w_unused_alarm = ^{alarm_time, alarm_arm, alarm_ack};
      assign alarm_flag     = 1'b0;
    end
  endgenerate

  // 12-hour view: 0 -> 12, 1..12 unchanged, 13..23 -> minus 12.
  always_comb begin
    w_hours12 = r_time.hours[3:0];
    if (r_time.hours == 5'd0) begin
      w_hours12 = 4'd12;
    end else if (r_time.hours > 5'd12) begin
      w_hours12 = 4'(r_time.hours - 5'd12);
    end
  end

  assign seconds  = r_time.seconds;
  assign minutes  = r_time.minutes;
  assign hours    = r_time.hours;
  assign hours12  = w_hours12;
  assign pm       = (r_time.hours >= 5'd12);
  assign sec_tick = r_sec_tick;
  assign set_err  = r_set_err;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Bench for rtc_timekeeper: two instances (TICK_DIV=1 and TICK_DIV=4) share
// stimulus and are checked against a seconds-of-day reference model.
module tb_rtc_timekeeper;

  // ---------------- clock / reset and DUT signals ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        set_en;
  logic [16:0] set_time;
  logic [10:0] alarm_time;
  logic        alarm_arm;
  logic        alarm_ack;

  logic [5:0] o1_seconds, o1_minutes, o4_seconds, o4_minutes;
  logic [4:0] o1_hours, o4_hours;
  logic [3:0] o1_hours12, o4_hours12;
  logic       o1_pm, o1_sec_tick, o1_set_err, o1_alarm_flag;
  logic       o4_pm, o4_sec_tick, o4_set_err, o4_alarm_flag;

  always #5 clk = ~clk;

  rtc_timekeeper #(.TICK_DIV(1), .ALARM_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .run(run), .set_en(set_en), .set_time(set_time),
    .alarm_time(alarm_time), .alarm_arm(alarm_arm), .alarm_ack(alarm_ack),
    .seconds(o1_seconds), .minutes(o1_minutes), .hours(o1_hours),
    .hours12(o1_hours12), .pm(o1_pm), .sec_tick(o1_sec_tick),
    .set_err(o1_set_err), .alarm_flag(o1_alarm_flag)
  );

  rtc_timekeeper #(.TICK_DIV(4), .ALARM_EN(1'b1)) u_dut4 (
    .clk(clk), .rst(rst), .run(run), .set_en(set_en), .set_time(set_time),
    .alarm_time(alarm_time), .alarm_arm(alarm_arm), .alarm_ack(alarm_ack),
    .seconds(o4_seconds), .minutes(o4_minutes), .hours(o4_hours),
    .hours12(o4_hours12), .pm(o4_pm), .sec_tick(o4_sec_tick),
    .set_err(o4_set_err), .alarm_flag(o4_alarm_flag)
  );

  // ---------------- reference model ----------------
  // Time kept as seconds since midnight; prescaler as a phase count.
  int m_tod[2];
  int m_ph[2];
  bit m_flag[2];
  bit m_tick[2];
  bit m_err[2];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int div_of(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_tod[k] = 0; m_ph[k] = 0; m_flag[k] = 0; m_tick[k] = 0; m_err[k] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int h, m, s, ah, am;
    bit valid, hit;
    h  = int'(set_time[16:12]);
    m  = int'(set_time[11:6]);
    s  = int'(set_time[5:0]);
    ah = int'(alarm_time[10:6]);
    am = int'(alarm_time[5:0]);
    valid = set_en && (h <= 23) && (m <= 59) && (s <= 59);
    for (int k = 0; k < 2; k++) begin
      hit = 0;
      m_tick[k] = 0;
      m_err[k]  = set_en && !valid;
      if (valid) begin
        m_tod[k] = h * 3600 + m * 60 + s;
        m_ph[k]  = 0;
      end else if (run) begin
        if (m_ph[k] == div_of(k) - 1) begin
          m_ph[k]   = 0;
          m_tod[k]  = (m_tod[k] + 1) % 86400;
          m_tick[k] = 1;
          hit = alarm_arm && (ah <= 23) && (am <= 59) && (m_tod[k] == ah * 3600 + am * 60);
        end else begin
          m_ph[k] = m_ph[k] + 1;
        end
      end
      if (hit) m_flag[k] = 1;
      else if (alarm_ack) m_flag[k] = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_inst(int k);
    int h, m, s, h12;
    logic [5:0] os, om;
    logic [4:0] oh;
    logic [3:0] oh12;
    logic opm, otk, oer, ofl;
    string p;
    s = m_tod[k] % 60;
    m = (m_tod[k] / 60) % 60;
    h = m_tod[k] / 3600;
    h12 = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
    if (k == 0) begin
      os = o1_seconds; om = o1_minutes; oh = o1_hours; oh12 = o1_hours12;
      opm = o1_pm; otk = o1_sec_tick; oer = o1_set_err; ofl = o1_alarm_flag;
    end else begin
      os = o4_seconds; om = o4_minutes; oh = o4_hours; oh12 = o4_hours12;
      opm = o4_pm; otk = o4_sec_tick; oer = o4_set_err; ofl = o4_alarm_flag;
    end
    p = $sformatf("div%0d", div_of(k));
    chk({p, ".seconds"},   32'(os),   s);
    chk({p, ".minutes"},   32'(om),   m);
    chk({p, ".hours"},     32'(oh),   h);
    chk({p, ".hours12"},   32'(oh12), h12);
    chk({p, ".pm"},        32'(opm),  (h >= 12) ? 1 : 0);
    chk({p, ".sec_tick"},  32'(otk),  32'(m_tick[k]));
    chk({p, ".set_err"},   32'(oer),  32'(m_err[k]));
    chk({p, ".alarm_flag"},32'(ofl),  32'(m_flag[k]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_inst(0);
    check_inst(1);
  endtask

  task automatic load(int h, int m, int s);
    set_en   = 1'b1;
    set_time = {5'(h), 6'(m), 6'(s)};
    step();
    set_en   = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int tmp;
    rst = 1'b1; run = 1'b0; set_en = 1'b0; set_time = '0;
    alarm_time = '0; alarm_arm = 1'b0; alarm_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_inst(0);
    check_inst(1);
    rst = 1'b0;

    // Free run from reset: div4 ticks on cycles 4, 8, 12.
    run = 1'b1;
    repeat (12) step();
    // Hold for 3 cycles, then resume: next div4 tick slips by 3.
    run = 1'b0;
    repeat (3) step();
    run = 1'b1;
    repeat (6) step();

    // Day rollover: 23:59:58 + 2 seconds.
    load(23, 59, 58);
    repeat (8) step();

    // Rejected loads keep time; a legal load lands on 12:30:15 (PM).
    run = 1'b0;
    load(24, 0, 0);
    load(5, 60, 0);
    load(5, 0, 60);
    load(12, 30, 15);
    step();

    // Load coincident with the div4 tick condition wins.
    run = 1'b1;
    for (int i = 0; i < 8 && m_ph[1] != 3; i++) step();
    load(1, 2, 3);
    repeat (5) step();

    // Alarm at 07:00, running from 06:59:58.
    alarm_time = {5'd7, 6'd0};
    alarm_arm  = 1'b1;
    load(6, 59, 58);
    repeat (9) step();
    alarm_arm  = 1'b0;
    step();
    alarm_ack  = 1'b1;
    step();
    alarm_ack  = 1'b0;
    alarm_arm  = 1'b1;
    // Ack held while the set event happens: the set wins.
    run = 1'b0;
    load(6, 59, 59);
    run = 1'b1;
    alarm_ack = 1'b1;
    repeat (4) step();
    alarm_ack = 1'b0;
    repeat (2) step();
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    // Loading the alarm time directly never raises the flag.
    run = 1'b0;
    load(7, 0, 0);
    repeat (2) step();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      run       = ($urandom_range(0, 9) != 0);
      set_en    = ($urandom_range(0, 29) == 0);
      set_time  = {5'($urandom_range(0, 25)), 6'($urandom_range(0, 61)), 6'($urandom_range(0, 61))};
      alarm_ack = ($urandom_range(0, 15) == 0);
      alarm_arm = ($urandom_range(0, 19) != 0);
      if (i % 50 == 0) begin
        tmp = (m_tod[0] / 60 + 1) % 1440;
        if ($urandom_range(0, 4) == 0) alarm_time = {5'(tmp / 60), 6'd60};
        else alarm_time = {5'(tmp / 60), 6'(tmp % 60)};
      end
      step();
    end
    set_en = 1'b0; alarm_ack = 1'b0;

    // Asynchronous reset between edges while showing 13:45:30.
    run = 1'b0;
    load(13, 45, 30);
    step();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_inst(0);
    check_inst(1);
    #1;
    rst = 1'b0;
    run = 1'b1;
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
